// File: rtl/vga_fill_ctrl.sv
// vga_fill_ctrl - fill engine and port-A arbiter for the VGA frame buffer.
//
// Fills a range of frame-buffer words with a 32-bit pattern using only the
// cycles in which the core leaves VGA memory port A idle. The core always
// wins port A, and its request passes straight through to the memory.
//
// Optional build macro: VGA_FILL_STALL_CNT_EN adds FillStallCnt, a
// saturating count of the FILL cycles lost to core traffic.
//
// Ports
//   QClk, Reset               clock (rising edge), async active-high reset
//   CoreWrEn/RdEn/Addr/WrData/ByteEn   core access to VGA memory
//   FillStart                 one-cycle launch pulse; samples FillBase,
//                             FillLen and FillPattern
//   FillAbort                 cancels an active fill
//   MemWrEn/RdEn/Addr/WrData/ByteEn    VGA memory port A
//   FillBusy                  high while a fill is in progress
//   FillDone                  one-cycle pulse when a fill ends normally
//   FillStallCnt              (optional) core-blocked FILL cycles
//
// state | meaning
// IDLE  | waiting for FillStart
// FILL  | writing pattern words whenever port A is free
// DONE  | single-cycle FillDone pulse, then back to IDLE
module vga_fill_ctrl #(
    parameter int ADDR_W    = 14,
    parameter int MEM_WORDS = 10240
) (
    input  logic              QClk,
    input  logic              Reset,
    input  logic              CoreWrEn,
    input  logic              CoreRdEn,
    input  logic [ADDR_W-1:0] CoreAddr,
    input  logic [31:0]       CoreWrData,
    input  logic [3:0]        CoreByteEn,
    input  logic              FillStart,
    input  logic [ADDR_W-1:0] FillBase,
    input  logic [ADDR_W-1:0] FillLen,
    input  logic [31:0]       FillPattern,
    input  logic              FillAbort,
    output logic              MemWrEn,
    output logic              MemRdEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWrData,
    output logic [3:0]        MemByteEn,
    output logic              FillBusy,
    output logic              FillDone
`ifdef VGA_FILL_STALL_CNT_EN
    ,
    output logic [15:0]       FillStallCnt
`endif
);

    localparam logic [ADDR_W-1:0] MEM_SIZE  = ADDR_W'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fill_ptr_q;
    logic [ADDR_W-1:0] remain_q;
    logic [31:0]       pat_q;
    logic              core_req;
    logic              fill_wr;
    logic              start_ok;
    logic [ADDR_W-1:0] base_wrapped;

    assign core_req = CoreWrEn | CoreRdEn;
    // Abort beats a pending write, and the core beats the engine.
    assign fill_wr  = (state_q == FILL) && !core_req && !FillAbort;
    assign start_ok = (state_q == IDLE) && FillStart;

    // The address space is less than twice the memory size, so one
    // conditional subtract is a full modulo reduction.
    assign base_wrapped = (FillBase >= MEM_SIZE) ? (FillBase - MEM_SIZE) : FillBase;

    always_ff @(posedge QClk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (FillStart) begin
                    state_d = (FillLen != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                if (FillAbort) begin
                    state_d = IDLE;
                end else if (fill_wr && (remain_q == ADDR_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Remain is a down-counter; the terminal compare above ends the fill.
    always_ff @(posedge QClk or posedge Reset) begin
        if (Reset) begin
            fill_ptr_q <= '0;
            remain_q   <= '0;
            pat_q      <= '0;
        end else if (start_ok && (FillLen != '0)) begin
            fill_ptr_q <= base_wrapped;
            remain_q   <= FillLen;
            pat_q      <= FillPattern;
        end else if (fill_wr) begin
            fill_ptr_q <= (fill_ptr_q == LAST_ADDR) ? '0 : fill_ptr_q + ADDR_W'(1);
            remain_q   <= remain_q - ADDR_W'(1);
        end
    end

    always_comb begin
        MemWrEn   = 1'b0;
        MemRdEn   = 1'b0;
        MemAddr   = '0;
        MemWrData = '0;
        MemByteEn = '0;
        if (core_req) begin
            MemWrEn   = CoreWrEn;
            MemRdEn   = CoreRdEn;
            MemAddr   = CoreAddr;
            MemWrData = CoreWrData;
            MemByteEn = CoreByteEn;
        end else if (fill_wr) begin
            MemWrEn   = 1'b1;
            MemAddr   = fill_ptr_q;
            MemWrData = pat_q;
            MemByteEn = 4'hF;
        end
    end

    assign FillBusy = (state_q == FILL);
    assign FillDone = (state_q == DONE);

`ifdef VGA_FILL_STALL_CNT_EN
    always_ff @(posedge QClk or posedge Reset) begin
        if (Reset) begin
            FillStallCnt <= '0;
        end else if (start_ok) begin
            FillStallCnt <= '0;
        end else if ((state_q == FILL) && core_req && (FillStallCnt != 16'hFFFF)) begin
            FillStallCnt <= FillStallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/vga_fill_ctrl.md
Name: vga_fill_ctrl

Overview:
- Hardware fill engine and port-A arbiter for the VGA frame-buffer memory (80 words/line x 128 line-groups = 10240 32-bit words).
- Sits between the core's VGA memory access signals and VGA memory port A.
- Fills or clears a range of words with a 32-bit pattern without core stores.
- The core always wins port A; the engine uses only idle cycles.

Parameters:
ADDR_W, 14, word-address width of VGA memory port A
MEM_WORDS, 10240, number of words in VGA memory; the fill pointer wraps here

Ports:
QClk  in  1  core clock, rising edge
Reset  in  1  asynchronous, active-high reset
CoreWrEn  in  1  core write request to VGA memory
CoreRdEn  in  1  core read request to VGA memory
CoreAddr  in  ADDR_W  core word address
CoreWrData  in  32  core write data
CoreByteEn  in  4  core byte enables
FillStart  in  1  one-cycle pulse that launches a fill
FillBase  in  ADDR_W  first word address of the fill, sampled on FillStart
FillLen  in  ADDR_W  number of words to fill, sampled on FillStart
FillPattern  in  32  fill data word, sampled on FillStart
FillAbort  in  1  cancels the active fill
MemWrEn  out  1  port-A write enable
MemRdEn  out  1  port-A read enable
MemAddr  out  ADDR_W  port-A word address
MemWrData  out  32  port-A write data
MemByteEn  out  4  port-A byte enables
FillBusy  out  1  high while a fill is in progress
FillDone  out  1  one-cycle pulse when a fill completes normally

Behaviour:
- Reset (async, any time, including mid-fill):
  - FSM goes to IDLE; pointer, remaining count and pattern registers clear to 0.
  - FillBusy=0, FillDone=0. All Mem* outputs are 0 while no core request is present.
  - A partially completed fill is not resumed after reset.
- Port-A mux (combinational, zero added latency):
  - If CoreWrEn or CoreRdEn is high, Mem* = core signals unchanged. Core read latency is the memory's own latency.
  - Otherwise, if FSM=FILL: MemWrEn=1, MemRdEn=0, MemAddr=FillPtr, MemWrData=PatReg, MemByteEn=4'hF.
  - Otherwise all Mem* outputs are 0.
- FSM states: IDLE, FILL, DONE.
  - IDLE:
    - FillStart with FillLen!=0: latch FillBase into FillPtr, FillLen into Remain, FillPattern into PatReg; go to FILL.
    - FillStart with FillLen==0: go straight to DONE; no writes are issued.
  - FILL, per cycle:
    - A write is issued only if there is no core request and FillAbort=0. On an issued write, FillPtr advances by 1 (MEM_WORDS-1 wraps to 0) and Remain decrements.
    - If the write just issued had Remain==1, go to DONE.
    - If the cycle was blocked by the core, hold FillPtr and Remain.
  - DONE: FillDone=1 for exactly this cycle; go to IDLE next cycle.
  - FillBusy=1 in FILL only.
- FillAbort:
  - Priority over a pending write. In FILL, no write is issued that cycle; go to IDLE next cycle with no FillDone.
  - In IDLE or DONE, FillAbort is ignored.
- FillStart while in FILL or DONE is ignored; no queueing.
- FillStart and FillAbort in the same IDLE cycle: the fill starts, and the abort is ignored.
- A FillBase outside the memory range is taken modulo MEM_WORDS at latch time.
- FillLen > MEM_WORDS is legal; the fill wraps and rewrites earlier words.
- Coherency:
  - Core and engine are never both granted in the same cycle.
  - A core write to a not-yet-filled address is overwritten by the later fill write.
  - Software must poll FillBusy to avoid this overwrite.
- Throughput: 1 word/cycle with no core traffic. Latency from the FillStart pulse to the first write is 1 cycle.

Optional Feature:
- Macro: VGA_FILL_STALL_CNT_EN.
- Defined:
  - Adds output FillStallCnt [15:0].
  - Cleared on reset and on each accepted FillStart.
  - Increments every FILL cycle in which a core request blocked the engine. Saturates at 16'hFFFF.
  - Holds its value after DONE or abort.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Basic fill: FillBase=100, FillLen=4, FillPattern=32'hA5A5A5A5, no core traffic -> writes to 100..103 on 4 consecutive cycles with ByteEn=F. FillDone pulses in the cycle after the last write. FillBusy is high for exactly 4 cycles.
- Core priority: FillLen=8, core writes on cycles 2 and 5 of the fill -> Mem* shows core data on those cycles. The engine finishes in 10 cycles with no skipped addresses. With VGA_FILL_STALL_CNT_EN, FillStallCnt=2.
- Wrap: FillBase=10238, FillLen=4 -> addresses 10238, 10239, 0, 1.
- Zero length / ignored start: FillLen=0 -> FillDone 1 cycle after FillStart, no writes. A second FillStart during FILL does not change FillPtr.
- Abort: FillLen=100, FillAbort after 10 writes -> no write in the abort cycle, IDLE next cycle, FillDone never asserts. A following fill behaves normally.
- Async reset mid-fill: assert Reset between clock edges after 3 writes -> FillBusy and Mem* drop to 0 immediately. After release there are no writes until a new FillStart.
